// File: rtl/iob_intr_pkt_gen_pkg.sv
// Shared NoC constants, flit field ranges and the queued interrupt request
// record used by the IOB interrupt packet generator.
package iob_intr_pkt_gen_pkg;

   localparam int unsigned NOC_DATA_WIDTH = 64;
   localparam int unsigned NOC_X_WIDTH    = 8;
   localparam int unsigned NOC_Y_WIDTH    = 8;

   localparam int unsigned MSG_DST_X_HI     = 49;
   localparam int unsigned MSG_DST_X_LO     = 42;
   localparam int unsigned MSG_DST_Y_HI     = 41;
   localparam int unsigned MSG_DST_Y_LO     = 34;
   localparam int unsigned MSG_DST_FBITS_HI = 33;
   localparam int unsigned MSG_DST_FBITS_LO = 30;
   localparam int unsigned MSG_LENGTH_HI    = 29;
   localparam int unsigned MSG_LENGTH_LO    = 22;
   localparam int unsigned MSG_TYPE_HI      = 21;
   localparam int unsigned MSG_TYPE_LO      = 14;

   localparam logic [3:0] NOC_FBITS_L1       = 4'b0000;
   localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'd33;

   typedef struct packed {
      logic [NOC_X_WIDTH-1:0] x;
      logic [NOC_Y_WIDTH-1:0] y;
      logic [1:0]             itype;
      logic [6:0]             vector;
      logic [31:0]            tileid;
   } intr_req_t;

   function automatic logic [NOC_DATA_WIDTH-1:0] build_header(intr_req_t r);
      logic [NOC_DATA_WIDTH-1:0] h;
      h = '0;
      h[MSG_DST_X_HI:MSG_DST_X_LO]         = r.x;
      h[MSG_DST_Y_HI:MSG_DST_Y_LO]         = r.y;
      h[MSG_DST_FBITS_HI:MSG_DST_FBITS_LO] = NOC_FBITS_L1;
      h[MSG_LENGTH_HI:MSG_LENGTH_LO]       = 8'd1;
      h[MSG_TYPE_HI:MSG_TYPE_LO]           = MSG_TYPE_INTERRUPT;
      return h;
   endfunction

   function automatic logic [NOC_DATA_WIDTH-1:0] build_payload(intr_req_t r);
      return {16'h0, r.tileid, 7'h0, r.itype, r.vector};
   endfunction

endpackage

// File: rtl/iob_req_fifo.sv
// Generic synchronous FIFO with registered occupancy count; also exposes the
// entry behind the head so a consumer can chain entries without a bubble.
module iob_req_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] rdata_nxt,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign rdata     = mem[rd_ptr_q];
   assign rdata_nxt = mem[rd_ptr_q + 1'b1];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/iob_intr_pkt_gen.sv
// Turns IOB interrupt requests into 2-flit NoC packets (header + payload),
// dropping requests whose tile id lies outside the mesh.
module iob_intr_pkt_gen
   import iob_intr_pkt_gen_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned X_TILES    = 1,
   parameter int unsigned Y_TILES    = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_val,
   output logic                      req_rdy,
   input  logic [31:0]               req_tileid,
   input  logic [1:0]                req_type,
   input  logic [6:0]                req_vector,
   output logic                      noc_out_val,
   input  logic                      noc_out_rdy,
   output logic [NOC_DATA_WIDTH-1:0] noc_out_data,
   output logic [CNT_WIDTH-1:0]      pkt_cnt,
   output logic [CNT_WIDTH-1:0]      drop_cnt,
   output logic                      err_bad_tile
);

   localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [32:0] NUM_TILES = 33'(X_TILES) * 33'(Y_TILES);

   typedef enum logic [1:0] {StIdle, StHdr, StBody} state_t;

   state_t                    state_q;
   logic                      val_q;
   logic [NOC_DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]      pkt_cnt_q, drop_cnt_q;
   logic                      err_q;

   intr_req_t     wr_entry, head, head_nxt;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          accept, tile_ok, push, pop;

   assign req_rdy = ~fifo_full;
   assign accept  = req_val & req_rdy;
   assign tile_ok = ({1'b0, req_tileid} < NUM_TILES);
   assign push    = accept & tile_ok;
   assign pop     = (state_q == StBody) & noc_out_rdy;

   always_comb begin
      wr_entry        = '0;
      wr_entry.x      = NOC_X_WIDTH'(req_tileid % X_TILES);
      wr_entry.y      = NOC_Y_WIDTH'(req_tileid / X_TILES);
      wr_entry.itype  = req_type;
      wr_entry.vector = req_vector;
      wr_entry.tileid = req_tileid;
   end

   iob_req_fifo #(
      .WIDTH ($bits(intr_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .wdata     (wr_entry),
      .pop       (pop),
      .rdata     (head),
      .rdata_nxt (head_nxt),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Chaining straight into the next header from BODY needs the second entry,
   // which is why the FIFO exposes rdata_nxt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         val_q     <= 1'b0;
         data_q    <= '0;
         pkt_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  state_q <= StHdr;
                  val_q   <= 1'b1;
                  data_q  <= build_header(head);
               end
            end
            StHdr: begin
               if (noc_out_rdy) begin
                  state_q <= StBody;
                  data_q  <= build_payload(head);
               end
            end
            StBody: begin
               if (noc_out_rdy) begin
                  if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
                  if (fifo_count > CW'(1)) begin
                     state_q <= StHdr;
                     data_q  <= build_header(head_nxt);
                  end else begin
                     state_q <= StIdle;
                     val_q   <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               val_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         err_q <= accept & ~tile_ok;
         if (accept && !tile_ok && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign noc_out_val  = val_q;
   assign noc_out_data = data_q;
   assign pkt_cnt      = pkt_cnt_q;
   assign drop_cnt     = drop_cnt_q;
   assign err_bad_tile = err_q;

endmodule

// File: tb/tb_iob_intr_pkt_gen.sv
// Directed bench for iob_intr_pkt_gen on a 2x2 mesh with 3-bit counters so
// that counter saturation is reachable in a short run.
module tb_iob_intr_pkt_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_val, req_rdy;
   logic [31:0] req_tileid;
   logic [1:0]  req_type;
   logic [6:0]  req_vector;
   logic        noc_out_val, noc_out_rdy;
   logic [63:0] noc_out_data;
   logic [2:0]  pkt_cnt, drop_cnt;
   logic        err_bad_tile;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc;
   int err_seen = 0;
   logic [63:0] flits[$];
   int          stamps[$];

   iob_intr_pkt_gen #(
      .FIFO_DEPTH (4),
      .X_TILES    (2),
      .Y_TILES    (2),
      .CNT_WIDTH  (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_val      (req_val),
      .req_rdy      (req_rdy),
      .req_tileid   (req_tileid),
      .req_type     (req_type),
      .req_vector   (req_vector),
      .noc_out_val  (noc_out_val),
      .noc_out_rdy  (noc_out_rdy),
      .noc_out_data (noc_out_data),
      .pkt_cnt      (pkt_cnt),
      .drop_cnt     (drop_cnt),
      .err_bad_tile (err_bad_tile)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // A flit transfers on the posedge following a negedge where val & rdy hold.
   always @(negedge clk) begin
      if (rst_n && noc_out_val && noc_out_rdy) begin
         flits.push_back(noc_out_data);
         stamps.push_back(cyc);
      end
      if (rst_n && err_bad_tile) err_seen++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_hdr(input int x, input int y);
      return (64'(x) << 42) | (64'(y) << 34) | (64'd1 << 22) | (64'd33 << 14);
   endfunction

   function automatic logic [63:0] exp_pay(input logic [31:0] id, input logic [1:0] t,
                                           input logic [6:0] v);
      return (64'(id) << 16) | (64'(t) << 7) | 64'(v);
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_req(input logic [31:0] id, input logic [1:0] t, input logic [6:0] v);
      bit got_rdy = 0;
      req_val = 1'b1; req_tileid = id; req_type = t; req_vector = v;
      for (int i = 0; i < 200 && !got_rdy; i++) begin
         @(negedge clk);
         if (req_rdy) got_rdy = 1;
      end
      if (!got_rdy) check_eq("push_timeout", 64'(got_rdy), 64'd1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      req_val = 1'b0;
   endtask

   task automatic wait_flits(input string tag, input int n);
      for (int i = 0; i < 300 && flits.size() < n; i++) @(posedge clk);
      check_eq(tag, 64'(flits.size()), 64'(n));
   endtask

   initial begin
      bit stable;
      logic [63:0] held;
      int s;

      rst_n = 1'b0; req_val = 1'b0; req_tileid = '0; req_type = '0; req_vector = '0;
      noc_out_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_req_rdy", 64'(req_rdy), 64'd1);
      check_eq("rst_val", 64'(noc_out_val), 64'd0);
      check_eq("rst_data", noc_out_data, 64'd0);
      check_eq("rst_cnts", {58'd0, pkt_cnt, drop_cnt}, 64'd0);
      check_eq("rst_err", 64'(err_bad_tile), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single packet, latency and payload
      push_req(32'd0, 2'd1, 7'd5);
      @(negedge clk);
      check_eq("t1_val_n1", 64'(noc_out_val), 64'd0);
      wait_flits("t1_nflits", 2);
      if (flits.size() == 2) begin
         check_eq("t1_hdr", flits[0], 64'h0000_0000_0048_4000);
         check_eq("t1_pay", flits[1], 64'h0000_0000_0000_0085);
         check_eq("t1_latency", 64'(stamps[0]), 64'(acc_cyc + 1));
      end
      @(negedge clk);
      check_eq("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
      check_eq("t1_val_idle", 64'(noc_out_val), 64'd0);
      flits.delete(); stamps.delete();

      // 2: valid far tile, then out-of-range tile
      @(posedge clk); #1;
      push_req(32'd3, 2'd3, 7'd127);
      wait_flits("t2_nflits", 2);
      if (flits.size() == 2) begin
         check_eq("t2_hdr", flits[0], 64'h0000_0404_0048_4000);
         check_eq("t2_pay", flits[1], exp_pay(32'd3, 2'd3, 7'd127));
      end
      flits.delete(); stamps.delete();
      @(posedge clk); #1;
      push_req(32'd4, 2'd0, 7'd1);
      @(negedge clk);
      check_eq("t2_err_pulse", 64'(err_bad_tile), 64'd1);
      @(negedge clk);
      check_eq("t2_err_clear", 64'(err_bad_tile), 64'd0);
      check_eq("t2_drop_cnt", 64'(drop_cnt), 64'd1);
      repeat (5) @(negedge clk);
      check_eq("t2_no_flits", 64'(flits.size()), 64'd0);
      check_eq("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

      // 3: back-pressure on header
      @(posedge clk); #1;
      noc_out_rdy = 1'b0;
      push_req(32'd2, 2'd2, 7'd9);
      for (int i = 0; i < 20 && !noc_out_val; i++) @(negedge clk);
      held = noc_out_data;
      check_eq("t3_hdr", held, exp_hdr(0, 1));
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (noc_out_val !== 1'b1 || noc_out_data !== held) stable = 0;
      end
      check_eq("t3_stable", 64'(stable), 64'd1);
      @(posedge clk); #1;
      noc_out_rdy = 1'b1;
      wait_flits("t3_nflits", 2);
      if (flits.size() == 2) begin
         check_eq("t3_pay", flits[1], exp_pay(32'd2, 2'd2, 7'd9));
         check_eq("t3_pay_next", 64'(stamps[1]), 64'(stamps[0] + 1));
      end
      flits.delete(); stamps.delete();

      // 4: fill the FIFO, then drain in order
      @(posedge clk); #1;
      noc_out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push_req(32'(i), 2'(i), 7'(10 + i));
      @(negedge clk);
      check_eq("t4_full_rdy", 64'(req_rdy), 64'd0);
      @(posedge clk); #1;
      noc_out_rdy = 1'b1;
      push_req(32'd0, 2'd3, 7'd20);
      push_req(32'd1, 2'd2, 7'd21);
      wait_flits("t4_nflits", 12);
      if (flits.size() == 12) begin
         for (int i = 0; i < 6; i++) begin
            logic [31:0] id;
            logic [1:0]  t;
            logic [6:0]  v;
            id = (i < 4) ? 32'(i) : 32'(i - 4);
            t  = (i < 4) ? 2'(i) : 2'(7 - i);
            v  = (i < 4) ? 7'(10 + i) : 7'(16 + i);
            check_eq($sformatf("t4_hdr%0d", i), flits[2*i], exp_hdr(int'(id % 2), int'(id / 2)));
            check_eq($sformatf("t4_pay%0d", i), flits[2*i+1], exp_pay(id, t, v));
         end
         check_eq("t4_b2b", 64'(stamps[7] - stamps[0]), 64'd7);
      end
      flits.delete(); stamps.delete();

      // 5: async reset while the payload is held
      @(posedge clk); #1;
      noc_out_rdy = 1'b0;
      push_req(32'd1, 2'd1, 7'd1);
      push_req(32'd2, 2'd1, 7'd2);
      for (int i = 0; i < 20 && !noc_out_val; i++) @(negedge clk);
      @(posedge clk); #1; noc_out_rdy = 1'b1;
      @(posedge clk); #1; noc_out_rdy = 1'b0;
      @(negedge clk);
      check_eq("t5_in_body", noc_out_data, exp_pay(32'd1, 2'd1, 7'd1));
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5_val_async", 64'(noc_out_val), 64'd0);
      check_eq("t5_data_async", noc_out_data, 64'd0);
      check_eq("t5_cnt_async", 64'(pkt_cnt), 64'd0);
      flits.delete(); stamps.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      noc_out_rdy = 1'b1;
      s = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (noc_out_val) s++;
      end
      check_eq("t5_no_val", 64'(s), 64'd0);
      check_eq("t5_no_flits", 64'(flits.size()), 64'd0);
      check_eq("t5_rdy", 64'(req_rdy), 64'd1);

      // 6: counter saturation (3-bit counters top out at 7)
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) push_req(32'(i % 4), 2'd0, 7'(i));
      wait_flits("t6_nflits6", 12);
      repeat (2) @(negedge clk);
      check_eq("t6_cnt6", 64'(pkt_cnt), 64'd6);
      @(posedge clk); #1;
      push_req(32'd3, 2'd0, 7'd0);
      wait_flits("t6_nflits7", 14);
      repeat (2) @(negedge clk);
      check_eq("t6_cnt7", 64'(pkt_cnt), 64'd7);
      @(posedge clk); #1;
      push_req(32'd0, 2'd0, 7'd0);
      push_req(32'd1, 2'd0, 7'd0);
      wait_flits("t6_nflits9", 18);
      repeat (2) @(negedge clk);
      check_eq("t6_cnt_sat", 64'(pkt_cnt), 64'd7);
      s = err_seen;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) push_req(32'd100 + 32'(i), 2'd0, 7'd0);
      repeat (2) @(negedge clk);
      check_eq("t6_drop_sat", 64'(drop_cnt), 64'd7);
      check_eq("t6_err_pulses", 64'(err_seen - s), 64'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
